// File: rtl/uart_rx_simplez_if.sv
// Receiver-side bundle: serial line in, decoded byte and status strobes out.
// master is the receiver itself; slave is whoever drives rx and consumes bytes.
interface uart_rx_simplez_if;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       busy;

    modport master (input rx, output data, rcv, ferr, busy);
    modport slave  (output rx, input data, rcv, ferr, busy);
endinterface

// File: rtl/uart_rx_simplez.sv
// 8N1 UART receiver for the simplez tx line: 2-flop synchroniser, mid-bit
// sampling off a per-state baud counter, one-cycle rcv/ferr strobes.
module uart_rx_simplez #(
    parameter int DIV = 104
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_simplez_if.master bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          rcv_q, rcv_d;
    logic          ferr_q, ferr_d;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic          tick;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            rcv_q   <= 1'b0;
            ferr_q  <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            rcv_q   <= rcv_d;
            ferr_q  <= ferr_d;
            sync_q  <= {sync_q[0], bus.rx};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        rcv_d   = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    cnt_d   = HALF;
                    state_d = START;
                end
            end
            START: begin
                // Half a bit in: still low means a real start bit, else a glitch.
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = FULL;
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    cnt_d = FULL;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = sh_q;
                        rcv_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
            end
            BRK: begin
                // Hold off until the line idles so a break is not a start bit.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data = data_q;
    assign bus.rcv  = rcv_q;
    assign bus.ferr = ferr_q;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_simplez.sv
// Randomised bench: frames are queued with their expected outcome and a
// monitor pops and checks each rcv/ferr strobe as it appears.
module tb_uart_rx_simplez;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_simplez_if bus ();

    uart_rx_simplez #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ferr;
        logic [7:0] b;
        int         t0;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_tot = 0;
    logic [7:0] model_data = 8'h00;
    bit         mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_tot++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) model_data = 8'h00;
        if (mon_en) begin
            if (bus.rcv || bus.ferr) begin
                exp_t e;
                int   lat;
                chk(!(bus.rcv && bus.ferr), "rcv_ferr_exclusive", {bus.rcv, bus.ferr}, 0);
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_pulse", {bus.rcv, bus.ferr}, 0);
                end else begin
                    e = sb.pop_front();
                    chk(bus.ferr == e.ferr, "pulse_kind_ferr", bus.ferr, e.ferr);
                    if (!e.ferr) begin
                        model_data = e.b;
                        lat = cyc - e.t0 - 1;
                        chk(lat >= 153 && lat <= 155, "rcv_latency", lat, 154);
                    end
                end
            end
            chk(bus.data == model_data, "data_hold", bus.data, model_data);
        end
    end

    task automatic drive_bit(input logic v);
        bus.rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok);
        exp_t e;
        e.ferr = !stop_ok;
        e.b    = b;
        e.t0   = cyc;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] rb;
        bit         ok;
        bus.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Quiet line after reset.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            chk({bus.busy, bus.rcv, bus.ferr} == 3'b000, "idle_quiet", {bus.busy, bus.rcv, bus.ferr}, 0);
        end
        chk(bus.data == 8'h00, "reset_data", bus.data, 0);

        // Back-to-back frames with no idle gap.
        send(8'h55, 1'b1);
        send(8'hA3, 1'b1);
        idle(2 * DIV);
        chk(bus.data == 8'hA3, "b2b_data", bus.data, 8'hA3);

        // Short glitch, then a normal frame.
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (DIV / 2 + 3) @(negedge clk);
        chk(bus.busy == 1'b0, "glitch_busy_drop", bus.busy, 0);
        idle(DIV);
        send(8'h0F, 1'b1);
        idle(2 * DIV);
        chk(bus.data == 8'h0F, "after_glitch_data", bus.data, 8'h0F);

        // Framing error followed by a held-low break.
        send(8'h7E, 1'b0);
        repeat (64) @(negedge clk);
        chk(bus.busy == 1'b1, "brk_busy_held", bus.busy, 1);
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        chk(bus.busy == 1'b0, "brk_release", bus.busy, 0);
        idle(4 * DIV);
        chk(bus.data == 8'h0F, "ferr_data_kept", bus.data, 8'h0F);

        // Reset in the middle of the data bits of 0xC4.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i == 2);
        bus.rx = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        chk({bus.busy, bus.rcv, bus.ferr} == 3'b000, "rst_mid_flags", {bus.busy, bus.rcv, bus.ferr}, 0);
        chk(bus.data == 8'h00, "rst_mid_data", bus.data, 0);
        idle(2 * DIV);
        send(8'h21, 1'b1);
        idle(2 * DIV);
        chk(bus.data == 8'h21, "post_rst_data", bus.data, 8'h21);

        // Byte a simplez program printing 'H' would emit.
        send(8'h48, 1'b1);
        idle(2 * DIV);
        chk(bus.data == 8'h48, "simplez_H", bus.data, 8'h48);

        // Random traffic: mostly good frames, some framing errors, random gaps.
        for (int n = 0; n < 30; n++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send(rb, ok);
            if (!ok) begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
                idle(DIV);
            end
            idle($urandom_range(0, 20));
        end

        idle(1);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        repeat (2 * DIV) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
